// File: rtl/lsu_mem_if.sv
// Core-side request/response handshake plus the synchronous data-memory port of the LSU.
// The master modport is the LSU itself; the slave modport is the core and memory around it.
interface lsu_mem_if #(
    parameter int ADDR_W = 11
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store unit: one access at a time against a synchronous-read word memory,
// with sub-word loads (sign/zero extension) and sub-word stores by read-modify-write.
module lsu_mem_master #(
    parameter int ADDR_W = 11
) (
    input  logic      clk,
    input  logic      reset,
    lsu_mem_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    state_t            state;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic              lat_we;
    logic              lat_unsigned;
    logic [1:0]        lat_size;
    logic [1:0]        lat_off;
    logic [15:0]       lat_wdata;

    logic              accept;
    logic              acc_err;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign accept = (state == IDLE) && bus.req_valid && req_ready_q;

    always_comb begin
        acc_err = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    end

    // Extraction and merge both work on the word arriving in CAP, selected by the latched offset.
    always_comb begin
        byte_val = bus.mem_rdata[{lat_off, 3'b000} +: 8];
        half_val = lat_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (lat_size)
            2'b00:   load_data = {{24{~lat_unsigned & byte_val[7]}}, byte_val};
            2'b01:   load_data = {{16{~lat_unsigned & half_val[15]}}, half_val};
            default: load_data = bus.mem_rdata;
        endcase

        merged = bus.mem_rdata;
        if (lat_size == 2'b00) merged[{lat_off, 3'b000} +: 8] = lat_wdata[7:0];
        else                   merged[{lat_off[1], 4'b0000} +: 16] = lat_wdata;
    end

    // NOTE: request latches carry no reset; they are only read after an accept has loaded them.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we       <= bus.req_we;
            lat_unsigned <= bus.req_unsigned;
            lat_size     <= bus.req_size;
            lat_off      <= bus.req_addr[1:0];
            lat_wdata    <= bus.req_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        if (acc_err) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (bus.req_we && bus.req_size == 2'b10) begin
                            state       <= WR;
                            mem_addr_q  <= bus.req_addr[ADDR_W+1:2];
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= bus.req_wdata;
                        end else begin
                            state      <= RD;
                            mem_addr_q <= bus.req_addr[ADDR_W+1:2];
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    if (lat_we) begin
                        state       <= WR;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged;
                    end else begin
                        state       <= RESP;
                        mem_addr_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= load_data;
                    end
                end
                WR: begin
                    state       <= RESP;
                    mem_we_q    <= 1'b0;
                    mem_wdata_q <= '0;
                    mem_addr_q  <= '0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
